kf8088_bus_cycle_generator: RTL and testbench

KF8088_BUS_CYCLE_GENERATOR -- requirements
Module: kf8088_bus_cycle_generator

---
 rtl/kf8088_bus_pkg.sv | 41 ++++
 rtl/kf8088_bus_cycle_generator_ready_sync.sv | 32 +++
 rtl/kf8088_bus_cycle_generator.sv | 174 +++++++++++++++++
 tb/tb_kf8088_bus_cycle_generator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kf8088_bus_pkg.sv
// kf8088_bus_pkg
// Shared definitions for the KF8088 bus cycle generator:
//   - bus_state_t : bus cycle state machine encoding (IDLE, T1, T2, T3, TW, T4)
//   - S2:S0 status codes presented to the 8288 bus controller
//   - is_read / is_write classification of status codes
//   - sat_inc8 : saturating 8-bit increment used by the wait counter
package kf8088_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_TW   = 3'd4,
        ST_T4   = 3'd5
    } bus_state_t;

    localparam logic [2:0] INTA    = 3'b000;
    localparam logic [2:0] IORC    = 3'b001;
    localparam logic [2:0] IOWC    = 3'b010;
    localparam logic [2:0] HALT    = 3'b011;
    localparam logic [2:0] MRDC0   = 3'b100;
    localparam logic [2:0] MRDC1   = 3'b101;
    localparam logic [2:0] MWTC    = 3'b110;
    localparam logic [2:0] PASSIVE = 3'b111;

    // Cycles that sample AD7:AD0 at the end of the data phase.
    function automatic logic is_read(input logic [2:0] code);
        return (code == INTA) || (code == IORC) || (code == MRDC0) || (code == MRDC1);
    endfunction

    // Cycles that drive write data onto AD7:AD0 after T1.
    function automatic logic is_write(input logic [2:0] code);
        return (code == IOWC) || (code == MWTC);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/kf8088_bus_cycle_generator_ready_sync.sv
// kf8088_ready_sync
// Two-flop synchronizer bringing the asynchronous bus READY into the clock
// domain. Both flops clear to 0 on reset, so a freshly reset bus sees
// "not ready" until READY has been sampled twice.
// Ports:
//   clock   : system clock
//   reset   : asynchronous, active-high reset
//   async_i : asynchronous input (bus READY)
//   sync_o  : synchronized output (ready_s)
module kf8088_ready_sync (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/kf8088_bus_cycle_generator.sv
// kf8088_bus_cycle_generator
// Runs one 8088 bus cycle (T1..T4 with optional TW wait states) per accepted
// request and drives S2:S0, A19:A8 and the multiplexed AD7:AD0 bus.
// Parameter:
//   WAIT_TIMEOUT     : maximum TW cycles before the cycle is aborted (1..255)
// Ports:
//   clock, reset                : system clock / async active-high reset
//   cycle_request               : requester asks for one bus cycle
//   cycle_type                  : S2:S0 code of the requested cycle
//   cycle_address               : 20-bit cycle address
//   cycle_write_data            : write data
//   cycle_accept                : pulse, request captured this cycle
//   cycle_done, cycle_error     : completion pulse, timeout flag
//   cycle_read_data             : captured read data
//   ready                       : asynchronous bus READY
//   processor_status            : S2:S0 to the 8288
//   address_high                : A19:A8
//   address_data_out/_oe/_in    : AD7:AD0 drive value, enable, sampled value
module kf8088_bus_cycle_generator
    import kf8088_bus_pkg::*;
#(
    parameter int WAIT_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cycle_request,
    input  logic [2:0]  cycle_type,
    input  logic [19:0] cycle_address,
    input  logic [7:0]  cycle_write_data,
    output logic        cycle_accept,
    output logic        cycle_done,
    output logic        cycle_error,
    output logic [7:0]  cycle_read_data,
    input  logic        ready,
    output logic [2:0]  processor_status,
    output logic [11:0] address_high,
    output logic [7:0]  address_data_out,
    output logic        address_data_oe,
    input  logic [7:0]  address_data_in
);

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_TIMEOUT);

    bus_state_t  state_q, state_d;
    logic [2:0]  type_q, type_d;
    logic [19:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic        pdone_q, pdone_d;
    logic        accept_c;
    logic        ready_s;

    kf8088_ready_sync u_ready_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (ready),
        .sync_o  (ready_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            type_q     <= PASSIVE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            pdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            pdone_q    <= pdone_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        pdone_d    = 1'b0;
        accept_c   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_T4: begin
                state_d = ST_IDLE;
                if (cycle_request) begin
                    accept_c = 1'b1;
                    type_d   = cycle_type;
                    addr_d   = cycle_address;
                    wdata_d  = cycle_write_data;
                    // A passive request completes without touching the bus.
                    if (cycle_type == PASSIVE) begin
                        pdone_d = 1'b1;
                    end else begin
                        state_d = ST_T1;
                    end
                end
            end
            ST_T1: begin
                timeout_d = 1'b0;
                state_d   = (type_q == HALT) ? ST_T4 : ST_T2;
            end
            ST_T2: begin
                wait_cnt_d = '0;
                state_d    = ST_T3;
            end
            ST_T3, ST_TW: begin
                if (ready_s) begin
                    state_d = ST_T4;
                    if (is_read(type_q)) begin
                        rdata_d = address_data_in;
                    end
                end else if ((state_q == ST_TW) && (wait_cnt_q >= WAIT_LIMIT)) begin
                    // Abort: read data is left untouched.
                    state_d   = ST_T4;
                    timeout_d = 1'b1;
                end else begin
                    state_d    = ST_TW;
                    wait_cnt_d = sat_inc8(wait_cnt_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        processor_status = PASSIVE;
        address_high     = '0;
        address_data_out = '0;
        address_data_oe  = 1'b0;

        unique case (state_q)
            ST_T1: begin
                processor_status = type_q;
                address_high     = addr_q[19:8];
                address_data_out = addr_q[7:0];
                address_data_oe  = 1'b1;
            end
            ST_T2, ST_T3, ST_TW, ST_T4: begin
                // T4 is passive on S2:S0 so the next T1 produces a fresh ALE edge.
                processor_status = (state_q == ST_T4) ? PASSIVE : type_q;
                address_high     = addr_q[19:8];
                if (is_write(type_q)) begin
                    address_data_out = wdata_q;
                    address_data_oe  = 1'b1;
                end
            end
            default: begin
                processor_status = PASSIVE;
            end
        endcase
    end

    // Accept is combinational on the request; masked while reset is held.
    assign cycle_accept    = accept_c & ~reset;
    assign cycle_done      = (state_q == ST_T4) | pdone_q;
    assign cycle_error     = (state_q == ST_T4) & timeout_q;
    assign cycle_read_data = rdata_q;

endmodule

// File: tb/tb_kf8088_bus_cycle_generator.sv
module tb_kf8088_bus_cycle_generator;

    logic        clock = 1'b0;
    logic        reset;
    logic        cycle_request;
    logic [2:0]  cycle_type;
    logic [19:0] cycle_address;
    logic [7:0]  cycle_write_data;
    logic        cycle_accept;
    logic        cycle_done;
    logic        cycle_error;
    logic [7:0]  cycle_read_data;
    logic        ready;
    logic [2:0]  processor_status;
    logic [11:0] address_high;
    logic [7:0]  address_data_out;
    logic        address_data_oe;
    logic [7:0]  address_data_in;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       err;
        logic [7:0] rd;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    logic [7:0] exp_rd = 8'h00;

    kf8088_bus_cycle_generator #(.WAIT_TIMEOUT(4)) dut (
        .clock            (clock),
        .reset            (reset),
        .cycle_request    (cycle_request),
        .cycle_type       (cycle_type),
        .cycle_address    (cycle_address),
        .cycle_write_data (cycle_write_data),
        .cycle_accept     (cycle_accept),
        .cycle_done       (cycle_done),
        .cycle_error      (cycle_error),
        .cycle_read_data  (cycle_read_data),
        .ready            (ready),
        .processor_status (processor_status),
        .address_high     (address_high),
        .address_data_out (address_data_out),
        .address_data_oe  (address_data_oe),
        .address_data_in  (address_data_in)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check all bus outputs at the falling edge, then advance to just after
    // the next rising edge where new stimulus may be applied.
    task automatic cyc(input string tag, input logic acc, input logic [2:0] st,
                       input logic [11:0] ah, input logic [7:0] ado,
                       input logic oe, input logic dn);
        @(negedge clock);
        chk({tag, "_accept"}, cycle_accept, acc);
        chk({tag, "_status"}, processor_status, st);
        chk({tag, "_ahigh"}, address_high, ah);
        chk({tag, "_adout"}, address_data_out, ado);
        chk({tag, "_oe"}, address_data_oe, oe);
        chk({tag, "_done"}, cycle_done, dn);
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: every completion pops the expectation pushed at request time.
    always @(negedge clock) begin
        if (cycle_done) begin
            n_cmp++;
            assert (sbq.size() > 0) else begin
                n_bad++;
                $error("FAIL unexpected_done observed=1 expected=0");
            end
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                chk("sb_error", cycle_error, mon_e.err);
                chk("sb_rdata", cycle_read_data, mon_e.rd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset            = 1'b1;
        cycle_request    = 1'b1;
        cycle_type       = 3'b001;
        cycle_address    = 20'h0003F;
        cycle_write_data = 8'h00;
        ready            = 1'b1;
        address_data_in  = 8'h77;

        // Reset state, with a request pending that must not be accepted.
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_status", processor_status, 3'b111);
        chk("rst_ahigh", address_high, 12'h000);
        chk("rst_adout", address_data_out, 8'h00);
        chk("rst_oe", address_data_oe, 1'b0);
        chk("rst_accept", cycle_accept, 1'b0);
        chk("rst_done", cycle_done, 1'b0);
        chk("rst_error", cycle_error, 1'b0);
        chk("rst_rdata", cycle_read_data, 8'h00);
        @(posedge clock);
        #1;

        // IORC at 0x0003F, honoured in the first cycle after reset release.
        reset = 1'b0;
        sbq.push_back('{err: 1'b0, rd: 8'h77});
        exp_rd = 8'h77;
        cyc("iorc_idle", 1, 3'b111, 12'h000, 8'h00, 0, 0);
        cycle_request = 1'b0;
        cyc("iorc_t1", 0, 3'b001, 12'h000, 8'h3F, 1, 0);
        cyc("iorc_t2", 0, 3'b001, 12'h000, 8'h00, 0, 0);
        cyc("iorc_t3", 0, 3'b001, 12'h000, 8'h00, 0, 0);
        cyc("iorc_t4", 0, 3'b111, 12'h000, 8'h00, 0, 1);
        cyc("iorc_post", 0, 3'b111, 12'h000, 8'h00, 0, 0);

        // MWTC 0x12345 / 0xA5.
        cycle_request    = 1'b1;
        cycle_type       = 3'b110;
        cycle_address    = 20'h12345;
        cycle_write_data = 8'hA5;
        sbq.push_back('{err: 1'b0, rd: exp_rd});
        cyc("mwtc_idle", 1, 3'b111, 12'h000, 8'h00, 0, 0);
        cycle_request = 1'b0;
        cyc("mwtc_t1", 0, 3'b110, 12'h123, 8'h45, 1, 0);
        cyc("mwtc_t2", 0, 3'b110, 12'h123, 8'hA5, 1, 0);
        cyc("mwtc_t3", 0, 3'b110, 12'h123, 8'hA5, 1, 0);
        cyc("mwtc_t4", 0, 3'b111, 12'h123, 8'hA5, 1, 1);
        cyc("mwtc_post", 0, 3'b111, 12'h000, 8'h00, 0, 0);

        // MRDC with ready_s low in T3 and two following waits: three TW.
        cycle_request   = 1'b1;
        cycle_type      = 3'b100;
        cycle_address   = 20'h00100;
        ready           = 1'b0;
        address_data_in = 8'h5A;
        sbq.push_back('{err: 1'b0, rd: 8'h5A});
        exp_rd = 8'h5A;
        cyc("mrdc_idle", 1, 3'b111, 12'h000, 8'h00, 0, 0);
        cycle_request = 1'b0;
        cyc("mrdc_t1", 0, 3'b100, 12'h001, 8'h00, 1, 0);
        cyc("mrdc_t2", 0, 3'b100, 12'h001, 8'h00, 0, 0);
        cyc("mrdc_t3", 0, 3'b100, 12'h001, 8'h00, 0, 0);
        ready = 1'b1;
        cyc("mrdc_tw1", 0, 3'b100, 12'h001, 8'h00, 0, 0);
        cyc("mrdc_tw2", 0, 3'b100, 12'h001, 8'h00, 0, 0);
        cyc("mrdc_tw3", 0, 3'b100, 12'h001, 8'h00, 0, 0);
        cyc("mrdc_t4", 0, 3'b111, 12'h001, 8'h00, 0, 1);
        cyc("mrdc_post", 0, 3'b111, 12'h000, 8'h00, 0, 0);

        // Timeout: ready held low, four TW then T4 with error, data unchanged.
        cycle_request   = 1'b1;
        cycle_type      = 3'b101;
        cycle_address   = 20'hFFFFF;
        ready           = 1'b0;
        address_data_in = 8'hC3;
        sbq.push_back('{err: 1'b1, rd: exp_rd});
        cyc("tmo_idle", 1, 3'b111, 12'h000, 8'h00, 0, 0);
        cycle_request = 1'b0;
        cyc("tmo_t1", 0, 3'b101, 12'hFFF, 8'hFF, 1, 0);
        cyc("tmo_t2", 0, 3'b101, 12'hFFF, 8'h00, 0, 0);
        cyc("tmo_t3", 0, 3'b101, 12'hFFF, 8'h00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("tmo_tw%0d", i + 1), 0, 3'b101, 12'hFFF, 8'h00, 0, 0);
        end
        cyc("tmo_t4", 0, 3'b111, 12'hFFF, 8'h00, 0, 1);
        cyc("tmo_post", 0, 3'b111, 12'h000, 8'h00, 0, 0);

        // Back-to-back INTA, INTA, HALT with the request held high.
        ready           = 1'b1;
        cycle_request   = 1'b1;
        cycle_type      = 3'b000;
        cycle_address   = 20'h00ABC;
        address_data_in = 8'h11;
        sbq.push_back('{err: 1'b0, rd: 8'h11});
        cyc("inta1_idle", 1, 3'b111, 12'h000, 8'h00, 0, 0);
        cycle_address = 20'h00DEF;
        cyc("inta1_t1", 0, 3'b000, 12'h00A, 8'hBC, 1, 0);
        cyc("inta1_t2", 0, 3'b000, 12'h00A, 8'h00, 0, 0);
        cyc("inta1_t3", 0, 3'b000, 12'h00A, 8'h00, 0, 0);
        address_data_in = 8'h22;
        sbq.push_back('{err: 1'b0, rd: 8'h22});
        exp_rd = 8'h22;
        cyc("inta1_t4", 1, 3'b111, 12'h00A, 8'h00, 0, 1);
        cycle_type    = 3'b011;
        cycle_address = 20'h00000;
        sbq.push_back('{err: 1'b0, rd: exp_rd});
        cyc("inta2_t1", 0, 3'b000, 12'h00D, 8'hEF, 1, 0);
        cyc("inta2_t2", 0, 3'b000, 12'h00D, 8'h00, 0, 0);
        cyc("inta2_t3", 0, 3'b000, 12'h00D, 8'h00, 0, 0);
        cyc("inta2_t4", 1, 3'b111, 12'h00D, 8'h00, 0, 1);
        cycle_request = 1'b0;
        cyc("halt_t1", 0, 3'b011, 12'h000, 8'h00, 1, 0);
        cyc("halt_t4", 0, 3'b111, 12'h000, 8'h00, 0, 1);
        cyc("halt_post", 0, 3'b111, 12'h000, 8'h00, 0, 0);

        // Reset during T2 of an MRDC: cycle abandoned, no completion.
        cycle_request = 1'b1;
        cycle_type    = 3'b100;
        cycle_address = 20'h54321;
        sbq.push_back('{err: 1'b0, rd: 8'h22});
        cyc("rmid_idle", 1, 3'b111, 12'h000, 8'h00, 0, 0);
        cycle_request = 1'b0;
        cyc("rmid_t1", 0, 3'b100, 12'h543, 8'h21, 1, 0);
        reset = 1'b1;
        sbq.delete();
        exp_rd = 8'h00;
        cyc("rmid_rst", 0, 3'b111, 12'h000, 8'h00, 0, 0);
        chk("rmid_rdata", cycle_read_data, 8'h00);
        chk("rmid_error", cycle_error, 1'b0);
        reset = 1'b0;
        cyc("rmid_idle1", 0, 3'b111, 12'h000, 8'h00, 0, 0);
        cyc("rmid_idle2", 0, 3'b111, 12'h000, 8'h00, 0, 0);

        // Passive request: accepted, done next cycle, no bus activity.
        cycle_request = 1'b1;
        cycle_type    = 3'b111;
        cycle_address = 20'hABCDE;
        sbq.push_back('{err: 1'b0, rd: exp_rd});
        cyc("pass_acc", 1, 3'b111, 12'h000, 8'h00, 0, 0);
        cycle_request = 1'b0;
        cyc("pass_done", 0, 3'b111, 12'h000, 8'h00, 0, 1);
        cyc("pass_post", 0, 3'b111, 12'h000, 8'h00, 0, 0);

        chk("sb_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
